spi_ctrl: RTL and testbench



---
 rtl/spi_ctrl_if.sv | 13 +
 rtl/spi_ctrl.sv | 124 ++++++++++++
 tb/tb_spi_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_if.sv
// CPU I/O bus view of the SPI controller: register strobes, write data, read-back words.
interface spi_ctrl_if;
    logic        data_en;
    logic        ctrl_en;
    logic        rd;
    logic        wr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] status;

    modport master (output data_en, ctrl_en, rd, wr, din, input dout, status);
    modport slave  (input data_en, ctrl_en, rd, wr, din, output dout, status);
endinterface

// File: rtl/spi_ctrl.sv
// SPI mode-0 master for the SD card and network module: 8-bit slow or 32-bit fast
// MSB-first transfers, started by a data-register write and polled through status.rdy.
module spi_ctrl #(
    parameter int unsigned SLOW_DIV = 32,
    parameter int unsigned FAST_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_ctrl_if.slave   bus,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic [1:0]  ss_n,
    output logic        net_en
);
    localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int unsigned CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int unsigned BIT_W   = 6;
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t             state;
    logic               fast;
    logic               rdy;
    logic [31:0]        tx;
    logic [31:0]        rx;
    logic [BIT_W-1:0]   bits;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   last;

    logic ctrl_wr;
    logic start;
    logic tick;
    logic unused_rd;

    assign ctrl_wr   = bus.wr & bus.ctrl_en;
    assign start     = bus.wr & bus.data_en & rdy;
    assign tick      = (cnt == last);
    assign unused_rd = bus.rd;

    assign bus.dout   = rx;
    assign bus.status = {31'b0, rdy};

    // Software-owned control bits; writable at any time, fast is consumed only at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n   <= 2'b11;
            fast   <= 1'b0;
            net_en <= 1'b0;
        end else if (ctrl_wr) begin
            ss_n   <= ~bus.din[1:0];
            fast   <= bus.din[2];
            net_en <= bus.din[3];
        end
    end

    // Bit engine: each bit spends DIV cycles low then DIV cycles high; miso taken on the rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy   <= 1'b1;
            sclk  <= 1'b0;
            mosi  <= 1'b1;
            tx    <= '0;
            rx    <= '0;
            bits  <= '0;
            cnt   <= '0;
            last  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOW;
                        rdy   <= 1'b0;
                        cnt   <= '0;
                        rx    <= '0;
                        if (fast) begin
                            tx   <= bus.din;
                            bits <= BIT_W'(32);
                            last <= FAST_LAST;
                            mosi <= bus.din[31];
                        end else begin
                            tx   <= {bus.din[7:0], 24'b0};
                            bits <= BIT_W'(8);
                            last <= SLOW_LAST;
                            mosi <= bus.din[7];
                        end
                    end
                end
                LOW: begin
                    if (tick) begin
                        state <= HIGH;
                        sclk  <= 1'b1;
                        cnt   <= '0;
                        rx    <= {rx[30:0], miso};
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (tick) begin
                        sclk <= 1'b0;
                        cnt  <= '0;
                        tx   <= {tx[30:0], 1'b0};
                        bits <= bits - BIT_W'(1);
                        if (bits == BIT_W'(1)) begin
                            state <= IDLE;
                            mosi  <= 1'b1;
                            rdy   <= 1'b1;
                        end else begin
                            state <= LOW;
                            mosi  <= tx[30];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ctrl.sv
// Scoreboarded bench for spi_ctrl: expected received words are queued at each accepted
// data write and compared when rdy rises; sclk timing and the mosi stream are monitored.
module tb_spi_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk, mosi, miso, net_en;
    logic [1:0] ss_n;
    bit         loop = 1'b1;
    logic       miso_fix = 1'b0;

    spi_ctrl_if bus ();

    spi_ctrl #(.SLOW_DIV(32), .FAST_DIV(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .sclk   (sclk),
        .mosi   (mosi),
        .miso   (miso),
        .ss_n   (ss_n),
        .net_en (net_en)
    );

    always #5 clk = ~clk;
    assign miso = loop ? mosi : miso_fix;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // scoreboard of expected dout words
    logic [31:0] sb[$];
    logic        rdy_prev = 1'b1;

    // sclk / mosi / rdy monitor statistics
    int          pulses, low_cycles, run;
    int          hi_min, hi_max, lo_min, lo_max;
    bit          seen_fall;
    logic        sclk_prev = 1'b0;
    logic [31:0] mo_bits;

    task automatic clear_stats();
        pulses = 0; low_cycles = 0; seen_fall = 1'b0; mo_bits = '0;
        hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            rdy_prev  = 1'b1;
            sclk_prev = 1'b0;
            run       = 0;
        end else begin
            if (bus.status[0] === 1'b1 && rdy_prev === 1'b0) begin
                if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else check("sb_dout", bus.dout, sb.pop_front());
            end
            rdy_prev = bus.status[0];
            if (bus.status[0] === 1'b0) low_cycles++;
            if (sclk !== sclk_prev) begin
                if (sclk_prev === 1'b1) begin
                    if (run < hi_min) hi_min = run;
                    if (run > hi_max) hi_max = run;
                end else if (seen_fall) begin
                    if (run < lo_min) lo_min = run;
                    if (run > lo_max) lo_max = run;
                end
                if (sclk === 1'b1) begin
                    pulses++;
                    mo_bits = {mo_bits[30:0], mosi};
                end else begin
                    seen_fall = 1'b1;
                end
                run = 1;
            end else begin
                run++;
            end
            sclk_prev = sclk;
        end
    end

    task automatic bus_write(input bit is_ctrl, input logic [31:0] data);
        @(negedge clk);
        bus.ctrl_en = is_ctrl;
        bus.data_en = !is_ctrl;
        bus.wr      = 1'b1;
        bus.din     = data;
        @(negedge clk);
        bus.ctrl_en = 1'b0;
        bus.data_en = 1'b0;
        bus.wr      = 1'b0;
    endtask

    task automatic wait_rdy(input string tag, input int limit);
        int n = 0;
        while (bus.status[0] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.status[0]), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bus.data_en = 1'b0; bus.ctrl_en = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.din = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_sclk",   32'(sclk),   32'd0);
        check("rst_mosi",   32'(mosi),   32'd1);
        check("rst_ss_n",   32'(ss_n),   32'd3);
        check("rst_net_en", 32'(net_en), 32'd0);
        check("rst_status", bus.status,  32'd1);
        check("rst_dout",   bus.dout,    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // slow loopback of 0xA5
        bus_write(1'b1, 32'h1);
        check("slow_ss_n", 32'(ss_n), 32'd2);
        clear_stats();
        sb.push_back(32'h0000_00A5);
        bus_write(1'b0, 32'hA5);
        check("slow_busy", bus.status, 32'd0);
        wait_rdy("slow_done", 2000);
        check("slow_low_cycles", 32'(low_cycles), 32'd512);
        check("slow_pulses",     32'(pulses),     32'd8);
        check("slow_mosi",       {24'b0, mo_bits[7:0]}, 32'hA5);
        check("slow_hi_min", 32'(hi_min), 32'd32);
        check("slow_hi_max", 32'(hi_max), 32'd32);
        check("slow_lo_min", 32'(lo_min), 32'd32);
        check("slow_lo_max", 32'(lo_max), 32'd32);

        // fast loopback of 0xDEADBEEF
        bus_write(1'b1, 32'h5);
        clear_stats();
        sb.push_back(32'hDEAD_BEEF);
        bus_write(1'b0, 32'hDEAD_BEEF);
        wait_rdy("fast_done", 1000);
        check("fast_low_cycles", 32'(low_cycles), 32'd128);
        check("fast_pulses",     32'(pulses),     32'd32);
        check("fast_mosi",       mo_bits,         32'hDEAD_BEEF);
        check("fast_hi_min", 32'(hi_min), 32'd2);
        check("fast_hi_max", 32'(hi_max), 32'd2);
        check("fast_lo_min", 32'(lo_min), 32'd2);
        check("fast_lo_max", 32'(lo_max), 32'd2);

        // data write while busy is ignored
        bus_write(1'b1, 32'h1);
        clear_stats();
        sb.push_back(32'h0000_00A5);
        bus_write(1'b0, 32'hA5);
        repeat (9) @(negedge clk);
        bus_write(1'b0, 32'h12);
        wait_rdy("busy_done", 2000);
        repeat (600) @(negedge clk);
        check("busy_low_cycles", 32'(low_cycles), 32'd512);
        check("busy_pulses",     32'(pulses),     32'd8);
        check("busy_mosi",       {24'b0, mo_bits[7:0]}, 32'hA5);
        check("busy_idle_rdy",   bus.status,      32'd1);

        // control write mid fast transfer
        bus_write(1'b1, 32'h5);
        clear_stats();
        sb.push_back(32'h3C5A_9612);
        bus_write(1'b0, 32'h3C5A_9612);
        repeat (20) @(negedge clk);
        bus_write(1'b1, 32'h0);
        check("midctrl_ss_n", 32'(ss_n), 32'd3);
        wait_rdy("midctrl_done", 1000);
        check("midctrl_low_cycles", 32'(low_cycles), 32'd128);
        check("midctrl_hi_max",     32'(hi_max),     32'd2);
        check("midctrl_pulses",     32'(pulses),     32'd32);

        // miso tied high, slow send of 0x00
        loop = 1'b0;
        miso_fix = 1'b1;
        bus_write(1'b1, 32'h1);
        clear_stats();
        sb.push_back(32'h0000_00FF);
        bus_write(1'b0, 32'h0);
        wait_rdy("ones_done", 2000);
        check("ones_dout", bus.dout, 32'h0000_00FF);
        bus_write(1'b1, 32'h8);
        check("net_en_set",  32'(net_en), 32'd1);
        check("net_en_ss_n", 32'(ss_n),   32'd3);

        // reset 100 cycles into a slow transfer
        loop = 1'b1;
        bus_write(1'b1, 32'h1);
        bus_write(1'b0, 32'hA5);
        repeat (99) @(negedge clk);
        check("pre_rst_busy", bus.status, 32'd0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_sclk",   32'(sclk),   32'd0);
        check("arst_mosi",   32'(mosi),   32'd1);
        check("arst_ss_n",   32'(ss_n),   32'd3);
        check("arst_net_en", 32'(net_en), 32'd0);
        check("arst_status", bus.status,  32'd1);
        check("arst_dout",   bus.dout,    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_rst_sclk",   32'(sclk),  32'd0);
        check("post_rst_status", bus.status, 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
